// File: rtl/sync_down_counter.sv
// sync_down_counter: WIDTH-bit down counter with reload register, IDLE/RUN/DONE
// control FSM, registered terminal-count and one-shot completion pulses.
// Optional macro DOWN_COUNTER_BORROW_EN adds a combinational borrow output for cascading.
module sync_down_counter #(
  parameter int              WIDTH          = 3,
  parameter logic [WIDTH-1:0] RELOAD_DEFAULT = {WIDTH{1'b1}},
  parameter bit              ONE_SHOT       = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             en,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             tc,
  output logic             done
`ifdef DOWN_COUNTER_BORROW_EN
  ,
  output logic             borrow
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             r_done;

  logic [WIDTH-1:0] w_dec;
  logic             w_zero;

  // Borrow-chain decrement: bit i toggles when every lower bit is zero
  always_comb begin
    logic v_low_zero;
    w_dec      = '0;
    v_low_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_dec[i]   = r_q[i] ^ v_low_zero;
      v_low_zero = v_low_zero & ~r_q[i];
    end
  end

  assign w_zero = (r_q == '0);

  // Control FSM, count register, reload register and the one-cycle pulses.
  // A load takes precedence over start/decrement and suppresses terminal events.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_q      <= RELOAD_DEFAULT;
      r_reload <= RELOAD_DEFAULT;
      r_tc     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_tc   <= 1'b0;
      r_done <= 1'b0;
      if (load) begin
        r_reload <= load_val;
        r_q      <= load_val;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_q     <= r_reload;
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            if (en) begin
              if (w_zero) begin
                r_tc <= 1'b1;
                if (ONE_SHOT) begin
                  // Hold at zero and report completion
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_q <= r_reload;
                end
              end else begin
                r_q <= w_dec;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign Q    = r_q;
  assign busy = (r_state == S_RUN);
  assign tc   = r_tc;
  assign done = r_done;

`ifdef DOWN_COUNTER_BORROW_EN
  // Asserted on the very edge the counter wraps, so the next stage decrements with it
  assign borrow = busy & en & w_zero & ~load;
`endif

endmodule

// File: tb/tb_sync_down_counter.sv
// Bench for sync_down_counter: periodic and one-shot instances share the stimulus.
// Table-driven vectors for the periodic instance, hand sequence for the one-shot one.
module tb_sync_down_counter;

  logic       clk = 1'b0;
  logic       reset, load, start, en;
  logic [2:0] load_val;

  logic [2:0] q_p, q_o;
  logic       busy_p, tc_p, done_p;
  logic       busy_o, tc_o, done_o;
`ifdef DOWN_COUNTER_BORROW_EN
  logic       borrow_p, borrow_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_down_counter #(.WIDTH(3), .RELOAD_DEFAULT(3'd7), .ONE_SHOT(1'b0)) dut_p (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .en(en),
    .Q(q_p), .busy(busy_p), .tc(tc_p), .done(done_p)
`ifdef DOWN_COUNTER_BORROW_EN
    , .borrow(borrow_p)
`endif
  );

  sync_down_counter #(.WIDTH(3), .RELOAD_DEFAULT(3'd7), .ONE_SHOT(1'b1)) dut_o (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .en(en),
    .Q(q_o), .busy(busy_o), .tc(tc_o), .done(done_o)
`ifdef DOWN_COUNTER_BORROW_EN
    , .borrow(borrow_o)
`endif
  );

  typedef struct {
    logic       rst;
    logic       ld;
    logic [2:0] lv;
    logic       st;
    logic       en;
    logic [2:0] q;
    logic       busy;
    logic       tc;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  // Expected state after the previous vector, per instance, for the borrow model
  logic [2:0] p_q[2];
  logic       p_busy[2];
  bit         p_valid[2];

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, ld, input logic [2:0] lv, input logic st, e,
                     input logic [2:0] q, input logic b, t, d);
    vec_t v;
    v.rst = rst; v.ld = ld; v.lv = lv; v.st = st; v.en = e;
    v.q = q; v.busy = b; v.tc = t; v.done = d;
    vecs.push_back(v);
  endtask

  // Drive one vector, check borrow before the edge, check registered outputs after it
  task automatic run_vec(input vec_t v, input int sel, input int idx);
    string pfx;
    pfx = (sel == 0) ? "per" : "os";
    reset = v.rst; load = v.ld; load_val = v.lv; start = v.st; en = v.en;
    #1;
`ifdef DOWN_COUNTER_BORROW_EN
    if (p_valid[sel])
      chk({pfx, "_borrow"}, idx, int'((sel == 0) ? borrow_p : borrow_o),
          int'(p_busy[sel] & v.en & (p_q[sel] == 3'd0) & ~v.ld));
`endif
    @(posedge clk);
    #1;
    chk({pfx, "_q"},    idx, int'((sel == 0) ? q_p    : q_o),    int'(v.q));
    chk({pfx, "_busy"}, idx, int'((sel == 0) ? busy_p : busy_o), int'(v.busy));
    chk({pfx, "_tc"},   idx, int'((sel == 0) ? tc_p   : tc_o),   int'(v.tc));
    chk({pfx, "_done"}, idx, int'((sel == 0) ? done_p : done_o), int'(v.done));
    p_q[sel]     = v.q;
    p_busy[sel]  = v.busy;
    p_valid[sel] = 1'b1;
  endtask

  vec_t h;

  initial begin
    reset = 1'b1; load = 1'b0; load_val = 3'd0; start = 1'b0; en = 1'b0;
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    p_q[0] = '0; p_q[1] = '0; p_busy[0] = 1'b0; p_busy[1] = 1'b0;

    // rst ld lv st en | q busy tc done
    // Reset held while other inputs toggle
    add(1, 1, 3'd2, 1, 1,  3'd7, 0, 0, 0);
    add(1, 0, 3'd0, 1, 0,  3'd7, 0, 0, 0);
    add(0, 0, 3'd0, 0, 1,  3'd7, 0, 0, 0);  // IDLE ignores en
    // Start, then continuous count with wrap
    add(0, 0, 3'd0, 1, 0,  3'd7, 1, 0, 0);
    for (int k = 6; k >= 0; k--) add(0, 0, 3'd0, 0, 1, 3'(k), 1, 0, 0);
    add(0, 0, 3'd0, 0, 1,  3'd7, 1, 1, 0);  // wrap to reload, tc pulse
    add(0, 0, 3'd0, 0, 1,  3'd6, 1, 0, 0);
    // en pattern 1,0,1,0 with start pulses in RUN
    add(0, 0, 3'd0, 1, 1,  3'd5, 1, 0, 0);
    add(0, 0, 3'd0, 1, 0,  3'd5, 1, 0, 0);
    add(0, 0, 3'd0, 0, 1,  3'd4, 1, 0, 0);
    add(0, 0, 3'd0, 1, 0,  3'd4, 1, 0, 0);
    for (int k = 3; k >= 0; k--) add(0, 0, 3'd0, 0, 1, 3'(k), 1, 0, 0);
    // Load at Q=0 with en: no tc, reload becomes 5
    add(0, 1, 3'd5, 0, 1,  3'd5, 1, 0, 0);
    for (int k = 4; k >= 0; k--) add(0, 0, 3'd0, 0, 1, 3'(k), 1, 0, 0);
    add(0, 0, 3'd0, 0, 1,  3'd5, 1, 1, 0);  // wrap reloads 5
    add(0, 0, 3'd0, 0, 1,  3'd4, 1, 0, 0);
    // Reset mid-RUN at Q=4, then relaunch from 7
    add(1, 0, 3'd0, 0, 1,  3'd7, 0, 0, 0);
    add(0, 0, 3'd0, 1, 1,  3'd7, 1, 0, 0);
    add(0, 0, 3'd0, 0, 1,  3'd6, 1, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) run_vec(vecs[i], 0, i);

    // One-shot instance: hand-written sequence
    vecs.delete();
    add(1, 0, 3'd0, 0, 0,  3'd7, 0, 0, 0);
    add(0, 1, 3'd3, 0, 0,  3'd3, 0, 0, 0);  // load in IDLE
    add(0, 0, 3'd0, 1, 0,  3'd3, 1, 0, 0);  // start
    add(0, 0, 3'd0, 0, 1,  3'd2, 1, 0, 0);
    add(0, 0, 3'd0, 0, 1,  3'd1, 1, 0, 0);
    add(0, 0, 3'd0, 0, 1,  3'd0, 1, 0, 0);
    add(0, 0, 3'd0, 0, 1,  3'd0, 0, 1, 1);  // terminal: DONE, pulses, busy low
    add(0, 0, 3'd0, 1, 1,  3'd0, 0, 0, 0);  // start in DONE ignored, back to IDLE
    add(0, 0, 3'd0, 0, 1,  3'd0, 0, 0, 0);  // IDLE holds 0
    add(0, 0, 3'd0, 1, 0,  3'd3, 1, 0, 0);  // relaunch from reload 3
    add(0, 1, 3'd0, 0, 1,  3'd0, 1, 0, 0);  // load 0 in RUN, no decrement
    add(0, 0, 3'd0, 0, 1,  3'd0, 0, 1, 1);  // first enabled cycle is terminal
    add(0, 0, 3'd0, 0, 0,  3'd0, 0, 0, 0);
    foreach (vecs[i]) begin
      h = vecs[i];
      run_vec(h, 1, i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
